// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: types and constants shared by the UART echo buffer.
//   tx_state_t  - states of the TX sequencer
//   CHAR_CR/LF  - control characters used for the CR -> CR,LF expansion
//   MODE_*      - encodings of the mode_i input
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [6:0] CHAR_CR = 7'h0D;
  localparam logic [6:0] CHAR_LF = 7'h0A;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_RAW     = 2'b01;
  localparam logic [1:0] MODE_CRLF    = 2'b10;
  localparam logic [1:0] MODE_RAW_ERR = 2'b11;

endpackage

// File: rtl/uart_echo_buffer_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i, rst_n_i - clock, synchronous active-low reset
//   push, din      - write request and data
//   pop            - read request; dout always shows the head entry
//   full, empty    - occupancy flags
//   level          - number of stored entries
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // room frees up in the same cycle when the head is being popped
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: queues characters from the RX core and echoes them
// to the TX core, optionally expanding CR into CR,LF.
//   clk_i, rst_n_i     - clock, synchronous active-low reset
//   rx_data_i          - received character
//   rx_data_ready_i    - RX data-ready level; rising edge = new character
//   rx_err_i           - parity/framing error on the current character
//   mode_i             - 00 off, 01 raw, 10 CR->CR,LF, 11 raw keeping errors
//   tx_busy_i          - TX core busy level
//   tx_data_o          - character to transmit, held until TX finishes
//   tx_start_o         - one-cycle start pulse to the TX core
//   fifo_level_o       - FIFO occupancy
//   overflow_o         - sticky overflow flag
//   drop_cnt_o         - saturating count of discarded characters
//
// TX sequencer states:
//   state     | meaning
//   IDLE      | pick next char: pending LF first, else FIFO head
//   START     | tx_start_o high for this cycle
//   WAIT_BUSY | wait for TX core to report busy
//   WAIT_DONE | wait for TX core to go idle; arm LF after a CR
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic                   rx_data_ready_i,
  input  logic                   rx_err_i,
  input  logic [1:0]             mode_i,
  input  logic                   tx_busy_i,
  output logic [DATA_W-1:0]      tx_data_o,
  output logic                   tx_start_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic              rdy_q;
  logic              cap;
  logic              keep;
  logic              err_drop;
  logic              ovf_drop;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              lf_pend;
  logic              cur_crlf;
  logic              load_lf;
  logic              load_fifo;
  logic              set_lf;
  logic              tx_start_nxt;

  // ---------------- capture and filtering ----------------
  assign cap      = rx_data_ready_i & ~rdy_q;
  assign keep     = cap & (mode_i != MODE_OFF) & (~rx_err_i | (mode_i == MODE_RAW_ERR));
  assign err_drop = cap & rx_err_i & ((mode_i == MODE_RAW) | (mode_i == MODE_CRLF));
  assign ovf_drop = keep & full & ~pop;
  assign push     = keep & ~ovf_drop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .pop     (pop),
    .din     (rx_data_i),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level_o)
  );

  // ---------------- TX sequencer ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      tx_start_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_o <= tx_start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (lf_pend || !empty) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy_i) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_lf      = 1'b0;
    load_fifo    = 1'b0;
    set_lf       = 1'b0;
    tx_start_nxt = 1'b0;
    if (state == IDLE) begin
      load_lf   = lf_pend;
      load_fifo = ~lf_pend & ~empty;
    end
    // the CR/LF decision was latched at pop time, so a later mode change
    // cannot affect a character already in flight
    if (state == WAIT_DONE && !tx_busy_i && cur_crlf && tx_data_o == DATA_W'(CHAR_CR))
      set_lf = 1'b1;
    tx_start_nxt = load_lf | load_fifo;
  end

  assign pop = load_fifo;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_data_o <= '0;
      lf_pend   <= 1'b0;
      cur_crlf  <= 1'b0;
    end else begin
      if (load_lf) begin
        tx_data_o <= DATA_W'(CHAR_LF);
        lf_pend   <= 1'b0;
        cur_crlf  <= 1'b0;
      end else if (load_fifo) begin
        tx_data_o <= fifo_dout;
        cur_crlf  <= (mode_i == MODE_CRLF);
      end
      if (set_lf) lf_pend <= 1'b1;
    end
  end

  // ---------------- edge detect, overflow, drop counter ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdy_q      <= 1'b0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      rdy_q <= rx_data_ready_i;
      if (ovf_drop) overflow_o <= 1'b1;
      if ((err_drop || ovf_drop) && drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer. A TX-core model raises busy
// for a few cycles after each start pulse and checks every transmitted
// character against a queue of expected characters.
module tb_uart_echo_buffer;
  import uart_echo_pkg::*;

  localparam int DATA_W = 7;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_data_ready_i;
  logic              rx_err_i;
  logic [1:0]        mode_i;
  logic              tx_busy_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_start_o;
  logic [LVL_W-1:0]  fifo_level_o;
  logic              overflow_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  logic              hold_busy;
  logic              model_busy;
  int                busy_cnt;
  int                n_starts;
  int                tests;
  int                fails;
  logic              in_flight;
  logic [DATA_W-1:0] last_tx;
  logic [DATA_W-1:0] exp_q [$];

  assign tx_busy_i = hold_busy | model_busy;

  always #5 clk_i = ~clk_i;

  uart_echo_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .rx_data_i       (rx_data_i),
    .rx_data_ready_i (rx_data_ready_i),
    .rx_err_i        (rx_err_i),
    .mode_i          (mode_i),
    .tx_busy_i       (tx_busy_i),
    .tx_data_o       (tx_data_o),
    .tx_start_o      (tx_start_o),
    .fifo_level_o    (fifo_level_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  // TX core model and scoreboard consumer
  initial begin
    logic [DATA_W-1:0] exp;
    model_busy = 1'b0;
    busy_cnt   = 0;
    n_starts   = 0;
    in_flight  = 1'b0;
    last_tx    = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_n_i === 1'b0) begin
        busy_cnt   = 0;
        model_busy = 1'b0;
        in_flight  = 1'b0;
        exp_q.delete();
      end else begin
        if (in_flight && tx_busy_i) begin
          tests++;
          if (tx_data_o !== last_tx) begin
            fails++;
            $display("FAIL tx_data_hold: got %h expected %h", tx_data_o, last_tx);
          end
        end
        if (tx_start_o === 1'b1) begin
          n_starts++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_start: got char %h expected no start", tx_data_o);
          end else begin
            exp = exp_q.pop_front();
            if (tx_data_o !== exp) begin
              fails++;
              $display("FAIL tx_char: got %h expected %h", tx_data_o, exp);
            end
          end
          last_tx   = tx_data_o;
          in_flight = 1'b1;
          busy_cnt  = 3;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        model_busy = (busy_cnt > 0);
        if (!(model_busy || hold_busy)) in_flight = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i         = 1'b0;
    rx_data_ready_i = 1'b0;
    rx_err_i        = 1'b0;
    hold_busy       = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic send_char(input logic [DATA_W-1:0] d, input logic err);
    @(negedge clk_i);
    rx_data_i       = d;
    rx_err_i        = err;
    rx_data_ready_i = 1'b1;
    @(negedge clk_i);
    rx_data_ready_i = 1'b0;
    rx_err_i        = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk_i); #1;
      if (exp_q.size() == 0 && !tx_busy_i && dut.state == IDLE &&
          fifo_level_o == '0 && !dut.lf_pend)
        done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: got %0d chars still pending, expected drain to idle", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n_i         = 1'b0;
    rx_data_i       = '0;
    rx_data_ready_i = 1'b0;
    rx_err_i        = 1'b0;
    mode_i          = MODE_RAW;
    hold_busy       = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    tests += 6;
    if (tx_data_o !== '0) begin fails++; $display("FAIL reset_tx_data: got %h expected 0", tx_data_o); end
    if (tx_start_o !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", tx_start_o); end
    if (fifo_level_o !== '0) begin fails++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    if (drop_cnt_o !== '0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
    if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_single();
    int base;
    do_reset();
    mode_i = MODE_RAW;
    base   = n_starts;
    @(negedge clk_i);
    exp_q.push_back(7'h41);
    rx_data_i       = 7'h41;
    rx_data_ready_i = 1'b1;
    @(posedge clk_i); #1;  // edge E
    tests += 2;
    if (fifo_level_o !== LVL_W'(1)) begin fails++; $display("FAIL single_level_E: got %0d expected 1", fifo_level_o); end
    if (tx_start_o !== 1'b0) begin fails++; $display("FAIL single_start_E: got %b expected 0", tx_start_o); end
    @(negedge clk_i);
    rx_data_ready_i = 1'b0;
    @(posedge clk_i); #1;  // edge E+1
    tests += 3;
    if (tx_start_o !== 1'b1) begin fails++; $display("FAIL single_start_E1: got %b expected 1", tx_start_o); end
    if (tx_data_o !== 7'h41) begin fails++; $display("FAIL single_data_E1: got %h expected 41", tx_data_o); end
    if (fifo_level_o !== '0) begin fails++; $display("FAIL single_level_E1: got %0d expected 0", fifo_level_o); end
    @(posedge clk_i); #1;  // edge E+2
    tests++;
    if (tx_start_o !== 1'b0) begin fails++; $display("FAIL single_start_E2: got %b expected 0", tx_start_o); end
    wait_idle("single");
    tests++;
    if (n_starts - base !== 1) begin fails++; $display("FAIL single_starts: got %0d expected 1", n_starts - base); end
  endtask

  task automatic test_burst();
    int base;
    do_reset();
    mode_i    = MODE_RAW;
    hold_busy = 1'b1;
    base      = n_starts;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(DATA_W'(8'h30 + i));
      send_char(DATA_W'(8'h30 + i), 1'b0);
    end
    repeat (2) @(negedge clk_i);
    tests += 2;
    if (fifo_level_o !== LVL_W'(4)) begin fails++; $display("FAIL burst_level: got %0d expected 4", fifo_level_o); end
    if (n_starts - base !== 1) begin fails++; $display("FAIL burst_starts_held: got %0d expected 1", n_starts - base); end
    hold_busy = 1'b0;
    wait_idle("burst");
    tests += 2;
    if (n_starts - base !== 5) begin fails++; $display("FAIL burst_starts: got %0d expected 5", n_starts - base); end
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL burst_overflow: got %b expected 0", overflow_o); end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    mode_i    = MODE_RAW;
    hold_busy = 1'b1;
    base      = n_starts;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) exp_q.push_back(DATA_W'(8'h60 + i));
      send_char(DATA_W'(8'h60 + i), 1'b0);
    end
    @(negedge clk_i);
    tests += 3;
    if (fifo_level_o !== LVL_W'(4)) begin fails++; $display("FAIL ovf_level: got %0d expected 4", fifo_level_o); end
    if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    if (drop_cnt_o !== CNT_W'(2)) begin fails++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt_o); end
    hold_busy = 1'b0;
    wait_idle("ovf");
    tests += 2;
    if (n_starts - base !== 5) begin fails++; $display("FAIL ovf_starts: got %0d expected 5", n_starts - base); end
    if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_full_pop();
    int base;
    do_reset();
    mode_i    = MODE_RAW;
    hold_busy = 1'b1;
    base      = n_starts;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(DATA_W'(8'h41 + i));
      send_char(DATA_W'(8'h41 + i), 1'b0);
    end
    repeat (2) @(negedge clk_i);
    tests++;
    if (fifo_level_o !== LVL_W'(4)) begin fails++; $display("FAIL fullpop_level_pre: got %0d expected 4", fifo_level_o); end
    // busy drops now: WAIT_DONE->IDLE next edge, pop on the edge after,
    // which is also the capture edge of the next character
    @(negedge clk_i);
    hold_busy = 1'b0;
    exp_q.push_back(7'h46);
    send_char(7'h46, 1'b0);
    tests += 3;
    if (fifo_level_o !== LVL_W'(4)) begin fails++; $display("FAIL fullpop_level: got %0d expected 4", fifo_level_o); end
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL fullpop_overflow: got %b expected 0", overflow_o); end
    if (drop_cnt_o !== '0) begin fails++; $display("FAIL fullpop_drop: got %0d expected 0", drop_cnt_o); end
    wait_idle("fullpop");
    tests++;
    if (n_starts - base !== 6) begin fails++; $display("FAIL fullpop_starts: got %0d expected 6", n_starts - base); end
  endtask

  task automatic test_crlf();
    int base;
    do_reset();
    mode_i = MODE_CRLF;
    base   = n_starts;
    exp_q.push_back(7'h0D);
    exp_q.push_back(7'h0A);
    exp_q.push_back(7'h41);
    send_char(7'h0D, 1'b0);
    send_char(7'h41, 1'b0);
    wait_idle("crlf");
    tests++;
    if (n_starts - base !== 3) begin fails++; $display("FAIL crlf_starts: got %0d expected 3", n_starts - base); end
  endtask

  task automatic test_err_filter();
    int base;
    do_reset();
    mode_i = MODE_RAW;
    base   = n_starts;
    send_char(7'h55, 1'b1);
    repeat (6) @(negedge clk_i);
    tests += 3;
    if (drop_cnt_o !== CNT_W'(1)) begin fails++; $display("FAIL err_drop: got %0d expected 1", drop_cnt_o); end
    if (fifo_level_o !== '0) begin fails++; $display("FAIL err_level: got %0d expected 0", fifo_level_o); end
    if (n_starts - base !== 0) begin fails++; $display("FAIL err_starts: got %0d expected 0", n_starts - base); end
    mode_i = MODE_RAW_ERR;
    exp_q.push_back(7'h55);
    send_char(7'h55, 1'b1);
    wait_idle("err_keep");
    tests += 2;
    if (n_starts - base !== 1) begin fails++; $display("FAIL errkeep_starts: got %0d expected 1", n_starts - base); end
    if (drop_cnt_o !== CNT_W'(1)) begin fails++; $display("FAIL errkeep_drop: got %0d expected 1", drop_cnt_o); end
  endtask

  task automatic test_mode_off();
    int base;
    do_reset();
    mode_i = MODE_OFF;
    base   = n_starts;
    send_char(7'h41, 1'b0);
    send_char(7'h42, 1'b1);
    repeat (6) @(negedge clk_i);
    tests += 3;
    if (n_starts - base !== 0) begin fails++; $display("FAIL off_starts: got %0d expected 0", n_starts - base); end
    if (drop_cnt_o !== '0) begin fails++; $display("FAIL off_drop: got %0d expected 0", drop_cnt_o); end
    if (fifo_level_o !== '0) begin fails++; $display("FAIL off_level: got %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_level_hold();
    int base;
    do_reset();
    mode_i = MODE_RAW;
    base   = n_starts;
    exp_q.push_back(7'h4C);
    @(negedge clk_i);
    rx_data_i       = 7'h4C;
    rx_data_ready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    rx_data_ready_i = 1'b0;
    wait_idle("hold");
    tests++;
    if (n_starts - base !== 1) begin fails++; $display("FAIL hold_starts: got %0d expected 1", n_starts - base); end
    exp_q.push_back(7'h4D);
    send_char(7'h4D, 1'b0);
    wait_idle("hold2");
    tests++;
    if (n_starts - base !== 2) begin fails++; $display("FAIL hold2_starts: got %0d expected 2", n_starts - base); end
  endtask

  task automatic test_drop_sat();
    do_reset();
    mode_i = MODE_RAW;
    for (int i = 0; i < 15; i++) send_char(DATA_W'(i), 1'b1);
    tests++;
    if (drop_cnt_o !== CNT_W'(15)) begin fails++; $display("FAIL sat_reach: got %0d expected 15", drop_cnt_o); end
    send_char(7'h11, 1'b1);
    send_char(7'h12, 1'b1);
    tests += 2;
    if (drop_cnt_o !== CNT_W'(15)) begin fails++; $display("FAIL sat_hold: got %0d expected 15", drop_cnt_o); end
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL sat_overflow: got %b expected 0", overflow_o); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    mode_i    = MODE_RAW;
    hold_busy = 1'b1;
    exp_q.push_back(7'h61);
    for (int i = 0; i < 4; i++) send_char(DATA_W'(8'h61 + i), 1'b0);
    @(negedge clk_i);
    tests += 2;
    if (dut.state !== WAIT_DONE) begin fails++; $display("FAIL midrst_pre_state: got %0d expected WAIT_DONE", dut.state); end
    if (fifo_level_o !== LVL_W'(3)) begin fails++; $display("FAIL midrst_pre_level: got %0d expected 3", fifo_level_o); end
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    tests += 6;
    if (fifo_level_o !== '0) begin fails++; $display("FAIL midrst_level: got %0d expected 0", fifo_level_o); end
    if (tx_start_o !== 1'b0) begin fails++; $display("FAIL midrst_start: got %b expected 0", tx_start_o); end
    if (dut.state !== IDLE) begin fails++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
    if (drop_cnt_o !== '0) begin fails++; $display("FAIL midrst_drop: got %0d expected 0", drop_cnt_o); end
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL midrst_overflow: got %b expected 0", overflow_o); end
    if (tx_data_o !== '0) begin fails++; $display("FAIL midrst_data: got %h expected 0", tx_data_o); end
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    hold_busy = 1'b0;
    base      = n_starts;
    repeat (20) @(negedge clk_i);
    tests++;
    if (n_starts - base !== 0) begin fails++; $display("FAIL midrst_quiet: got %0d starts expected 0", n_starts - base); end
    exp_q.push_back(7'h65);
    send_char(7'h65, 1'b0);
    wait_idle("midrst");
    tests++;
    if (n_starts - base !== 1) begin fails++; $display("FAIL midrst_after: got %0d expected 1", n_starts - base); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_crlf();
    test_err_filter();
    test_mode_off();
    test_level_hold();
    test_drop_sat();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
